// File: rtl/ovc_release_tracker.sv
// rtl/ovc_release_tracker.sv - per-output-port output-VC state and credit tracker
module ovc_release_tracker #(
   parameter int num_vcs     = 4,
   parameter int buffer_size = 8,
   parameter int reset_type  = 0   // 0 = RESET_TYPE_SYNC, the only implemented type
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [0:num_vcs-1]                            gnt_ovc,
   input  logic                                          flit_valid,
   input  logic [((num_vcs > 1) ? $clog2(num_vcs) : 1)-1:0] flit_ovc,
   input  logic                                          flit_tail,
   input  logic                                          credit_valid,
   input  logic [((num_vcs > 1) ? $clog2(num_vcs) : 1)-1:0] credit_ovc,
   output logic [0:num_vcs-1]                            elig_ovc,
   output logic [0:num_vcs-1]                            credit_avail_ovc,
   output logic [0:num_vcs-1]                            allocated_ovc,
   output logic                                          error
);

   localparam int IW = (num_vcs > 1) ? $clog2(num_vcs) : 1;
   localparam int CW = $clog2(buffer_size + 1);
   localparam int RESET_TYPE_SYNC = 0;
   localparam logic [CW-1:0] FULL_C = CW'(buffer_size);
   localparam logic [CW:0]   FULL_S = (CW + 1)'(buffer_size);
   localparam logic [IW:0]   NV     = (IW + 1)'(num_vcs);

   typedef enum logic [1:0] {IDLE, ALLOC, DRAIN} vc_state_t;

   vc_state_t     state_q   [num_vcs];
   vc_state_t     state_nxt [num_vcs];
   logic [CW-1:0] cnt_q     [num_vcs];
   logic [CW-1:0] cnt_nxt   [num_vcs];
   logic [CW:0]   sum       [num_vcs];
   logic [num_vcs-1:0] f_hit, c_hit, f_ok;
   logic          multi_gnt, flit_in_range, credit_in_range, err_nxt;
   logic          rst_sync;

   // Only the synchronous reset type is implemented; other types leave reset inert.
   assign rst_sync = reset && (reset_type == RESET_TYPE_SYNC);

   // Next-state, next-credit and error evaluation for every VC.
   always_comb begin
      multi_gnt       = ($countones(gnt_ovc) > 1);
      flit_in_range   = ({1'b0, flit_ovc} < NV);
      credit_in_range = ({1'b0, credit_ovc} < NV);
      err_nxt = error | multi_gnt
              | (flit_valid && !flit_in_range)
              | (credit_valid && !credit_in_range);
      for (int v = 0; v < num_vcs; v++) begin
         f_hit[v] = flit_valid && flit_in_range && (flit_ovc == IW'(v));
         c_hit[v] = credit_valid && credit_in_range && (credit_ovc == IW'(v));
         // A flit is only honoured on an owned VC that has (or is just getting) a credit.
         f_ok[v]  = f_hit[v] && (state_q[v] == ALLOC) && ((cnt_q[v] != '0) || c_hit[v]);
         sum[v]   = {1'b0, cnt_q[v]} + (CW + 1)'(c_hit[v]) - (CW + 1)'(f_ok[v]);
         state_nxt[v] = state_q[v];
         cnt_nxt[v]   = cnt_q[v];
         if (f_hit[v] && !f_ok[v])
            err_nxt = 1'b1;
         if (gnt_ovc[v] && (state_q[v] != IDLE))
            err_nxt = 1'b1;
         if (sum[v] > FULL_S) begin
            err_nxt    = 1'b1;
            cnt_nxt[v] = FULL_C;
         end else begin
            cnt_nxt[v] = sum[v][CW-1:0];
         end
         case (state_q[v])
            IDLE:    if (gnt_ovc[v] && !multi_gnt) state_nxt[v] = ALLOC;
            ALLOC:   if (f_ok[v] && flit_tail)
                        state_nxt[v] = (cnt_nxt[v] == FULL_C) ? IDLE : DRAIN;
            DRAIN:   if (cnt_nxt[v] == FULL_C) state_nxt[v] = IDLE;
            default: state_nxt[v] = IDLE;
         endcase
      end
   end

   // State, credit counters and all outputs registered together.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         for (int v = 0; v < num_vcs; v++) begin
            state_q[v] <= IDLE;
            cnt_q[v]   <= FULL_C;
         end
         elig_ovc         <= '1;
         credit_avail_ovc <= '1;
         allocated_ovc    <= '0;
         error            <= 1'b0;
      end else begin
         for (int v = 0; v < num_vcs; v++) begin
            state_q[v]          <= state_nxt[v];
            cnt_q[v]            <= cnt_nxt[v];
            elig_ovc[v]         <= (state_nxt[v] == IDLE);
            allocated_ovc[v]    <= (state_nxt[v] == ALLOC);
            credit_avail_ovc[v] <= (cnt_nxt[v] != '0);
         end
         error <= err_nxt;
      end
   end

endmodule

// File: tb/tb_ovc_release_tracker.sv
// tb/tb_ovc_release_tracker.sv - self-checking bench for ovc_release_tracker
module tb_ovc_release_tracker;

   localparam int NV = 4;
   localparam int B  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [0:NV-1] gnt_ovc;
   logic          flit_valid;
   logic [1:0]    flit_ovc;
   logic          flit_tail;
   logic          credit_valid;
   logic [1:0]    credit_ovc;
   logic [0:NV-1] elig_ovc;
   logic [0:NV-1] credit_avail_ovc;
   logic [0:NV-1] allocated_ovc;
   logic          error;

   ovc_release_tracker #(.num_vcs(NV), .buffer_size(B), .reset_type(0)) dut (
      .clk(clk), .reset(reset), .gnt_ovc(gnt_ovc),
      .flit_valid(flit_valid), .flit_ovc(flit_ovc), .flit_tail(flit_tail),
      .credit_valid(credit_valid), .credit_ovc(credit_ovc),
      .elig_ovc(elig_ovc), .credit_avail_ovc(credit_avail_ovc),
      .allocated_ovc(allocated_ovc), .error(error)
   );

   always #5 clk = ~clk;

   // Reference model: 0 = free, 1 = owned by a packet, 2 = waiting for credits
   int m_st  [NV];
   int m_cnt [NV];
   bit m_err;
   int checks   = 0;
   int failures = 0;

   function automatic void model_reset();
      for (int v = 0; v < NV; v++) begin
         m_st[v]  = 0;
         m_cnt[v] = B;
      end
      m_err = 0;
   endfunction

   function automatic void model_cycle(input logic [0:NV-1] g, input bit fv, input int fo,
                                       input bit ft, input bit cv, input int co);
      int ngr;
      ngr = 0;
      for (int v = 0; v < NV; v++) if (g[v]) ngr++;
      if (ngr > 1) m_err = 1;
      for (int v = 0; v < NV; v++) begin
         bit f, c, sent;
         int n;
         f = fv && (fo == v);
         c = cv && (co == v);
         sent = f && (m_st[v] == 1) && (m_cnt[v] > 0 || c);
         if (f && !sent) m_err = 1;
         if (g[v] && m_st[v] != 0) m_err = 1;
         n = m_cnt[v] + (c ? 1 : 0) - (sent ? 1 : 0);
         if (n > B) begin
            m_err = 1;
            n = B;
         end
         if (m_st[v] == 0 && g[v] && ngr == 1) m_st[v] = 1;
         else if (m_st[v] == 1 && sent && ft) m_st[v] = (n == B) ? 0 : 2;
         else if (m_st[v] == 2 && n == B) m_st[v] = 0;
         m_cnt[v] = n;
      end
   endfunction

   task automatic check_model(input string tag);
      logic [0:NV-1] e_el, e_ca, e_al;
      for (int v = 0; v < NV; v++) begin
         e_el[v] = (m_st[v] == 0);
         e_al[v] = (m_st[v] == 1);
         e_ca[v] = (m_cnt[v] != 0);
      end
      checks++;
      assert (elig_ovc === e_el) else begin
         failures++;
         $error("FAIL %s elig_ovc got=%b exp=%b", tag, elig_ovc, e_el);
      end
      checks++;
      assert (allocated_ovc === e_al) else begin
         failures++;
         $error("FAIL %s allocated_ovc got=%b exp=%b", tag, allocated_ovc, e_al);
      end
      checks++;
      assert (credit_avail_ovc === e_ca) else begin
         failures++;
         $error("FAIL %s credit_avail_ovc got=%b exp=%b", tag, credit_avail_ovc, e_ca);
      end
      checks++;
      assert (error === m_err) else begin
         failures++;
         $error("FAIL %s error got=%b exp=%b", tag, error, m_err);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s got=%b exp=%b", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      gnt_ovc = '0; flit_valid = 0; flit_ovc = '0; flit_tail = 0;
      credit_valid = 0; credit_ovc = '0;
   endtask

   task automatic step(input string tag, input logic [0:NV-1] g, input bit fv, input int fo,
                       input bit ft, input bit cv, input int co);
      gnt_ovc = g; flit_valid = fv; flit_ovc = fo[1:0]; flit_tail = ft;
      credit_valid = cv; credit_ovc = co[1:0];
      model_cycle(g, fv, fo, ft, cv, co);
      @(posedge clk);
      #1;
      idle_inputs();
      check_model(tag);
   endtask

   task automatic do_reset(input string tag);
      int r;
      r = $urandom;
      reset = 1;
      gnt_ovc = 4'(r); flit_valid = r[4]; flit_ovc = r[6:5]; flit_tail = r[7];
      credit_valid = r[8]; credit_ovc = r[10:9];
      @(posedge clk);
      #1;
      reset = 0;
      idle_inputs();
      model_reset();
      check_model(tag);
      check_bit({tag, "_err_clear"}, error, 1'b0);
   endtask

   initial begin
      logic [0:NV-1] g;
      bit fv, ft, cv, found;
      int fo, co, r;

      reset = 1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      do_reset("reset");

      // Grant VC2, three-flit packet, then three credits release it
      step("g2_grant", 4'b0010, 0, 0, 0, 0, 0);
      step("g2_f1", '0, 1, 2, 0, 0, 0);
      step("g2_f2", '0, 1, 2, 0, 0, 0);
      step("g2_tail", '0, 1, 2, 1, 0, 0);
      step("g2_gap", '0, 0, 0, 0, 0, 0);
      check_bit("g2_drain_not_elig", elig_ovc[2], 1'b0);
      step("g2_c1", '0, 0, 0, 0, 1, 2);
      step("g2_c2", '0, 0, 0, 0, 1, 2);
      check_bit("g2_still_drain", elig_ovc[2], 1'b0);
      step("g2_c3", '0, 0, 0, 0, 1, 2);
      check_bit("g2_released", elig_ovc[2], 1'b1);

      // Exhaust VC0 credits, then overrun
      do_reset("reset_b");
      step("v0_grant", 4'b1000, 0, 0, 0, 0, 0);
      for (int i = 0; i < B; i++) step("v0_flit", '0, 1, 0, 0, 0, 0);
      check_bit("v0_no_credit", credit_avail_ovc[0], 1'b0);
      check_bit("v0_no_err_yet", error, 1'b0);
      step("v0_overrun", '0, 1, 0, 0, 0, 0);
      check_bit("v0_overrun_err", error, 1'b1);
      check_bit("v0_count_held", credit_avail_ovc[0], 1'b0);

      // Single-flit packets on VC1 with same-cycle credits
      do_reset("reset_c");
      step("v1_grant", 4'b0100, 0, 0, 0, 0, 0);
      step("v1_tail_cred", '0, 1, 1, 1, 1, 1);
      check_bit("v1_direct_idle", elig_ovc[1], 1'b1);
      step("v1_grant2", 4'b0100, 0, 0, 0, 0, 0);
      step("v1_head", '0, 1, 1, 0, 0, 0);
      step("v1_tail_cred2", '0, 1, 1, 1, 1, 1);
      check_bit("v1_drain", elig_ovc[1], 1'b0);
      step("v1_last_cred", '0, 0, 0, 0, 1, 1);
      check_bit("v1_release", elig_ovc[1], 1'b1);
      check_bit("v1_no_err", error, 1'b0);

      // Illegal re-grant and credit overflow
      do_reset("reset_d");
      step("v3_grant", 4'b0001, 0, 0, 0, 0, 0);
      step("v3_regrant", 4'b0001, 0, 0, 0, 0, 0);
      check_bit("v3_regrant_err", error, 1'b1);
      check_bit("v3_stays_alloc", allocated_ovc[3], 1'b1);
      do_reset("reset_e");
      step("v0_cred_full", '0, 0, 0, 0, 1, 0);
      check_bit("v0_overflow_err", error, 1'b1);
      step("multi_gnt", 4'b0110, 0, 0, 0, 0, 0);
      check_bit("multi_gnt_suppressed", elig_ovc[1], 1'b1);

      // Reset mid-drain
      do_reset("reset_f");
      step("v2_grant", 4'b0010, 0, 0, 0, 0, 0);
      step("v2_tail", '0, 1, 2, 1, 0, 0);
      step("v2_extra_err", '0, 1, 0, 0, 0, 0);
      do_reset("reset_mid_drain");

      // Randomised traffic against the model
      for (int i = 0; i < 800; i++) begin
         if (m_err && $urandom_range(9) == 0) begin
            do_reset("rnd_reset");
         end else begin
            g = '0;
            r = $urandom_range(99);
            if (r < 30) g[$urandom_range(NV - 1)] = 1'b1;
            else if (r < 33) g = 4'($urandom);
            fv = ($urandom_range(99) < 60);
            fo = $urandom_range(NV - 1);
            ft = ($urandom_range(3) == 0);
            if ($urandom_range(7) != 0) begin
               found = 0;
               for (int k = 0; k < NV; k++)
                  if (!found && m_st[(fo + k) % NV] == 1 && m_cnt[(fo + k) % NV] > 0) begin
                     fo = (fo + k) % NV;
                     found = 1;
                  end
               if (!found) fv = 0;
            end
            cv = ($urandom_range(99) < 50);
            co = $urandom_range(NV - 1);
            if ($urandom_range(7) != 0) begin
               found = 0;
               for (int k = 0; k < NV; k++)
                  if (!found && m_cnt[(co + k) % NV] < B) begin
                     co = (co + k) % NV;
                     found = 1;
                  end
               if (!found) cv = 0;
            end
            step("rnd", g, fv, fo, ft, cv, co);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
